// File: rtl/sbox_shift_rows_collector_if.sv
// Byte-serial S-box result stream in, 128-bit ShiftRows state out.
// master = issue controller / consumer side, slave = collector.
interface sbox_shift_rows_collector_if;
    logic         sb_issue;
    logic         sb_ready;
    logic [7:0]   sb_byte;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;
    logic         overflow;

    modport master (
        output sb_issue, sb_byte, out_ready,
        input  sb_ready, out_state, out_valid, overflow
    );

    modport slave (
        input  sb_issue, sb_byte, out_ready,
        output sb_ready, out_state, out_valid, overflow
    );
endinterface

// File: rtl/sbox_shift_rows_collector.sv
// Collects 16 S-box output bytes, applies ShiftRows and hands the state
// downstream on a valid/ready handshake; credits throttle the issuer.
module sbox_shift_rows_collector #(
    parameter int unsigned SBOX_LAT = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    sbox_shift_rows_collector_if.slave bus
);
    logic [4:0]          res_cnt;
    logic [4:0]          cap_cnt;
    logic [SBOX_LAT-1:0] vpipe;
    logic [7:0]          bank [16];
    logic [127:0]        state_q;
    logic [127:0]        sr_state;
    logic                valid_q;
    logic                overflow_q;
    logic                ready;
    logic                accept;
    logic                capture;
    logic                complete;
    logic                transfer;

    always_comb begin
        ready    = (res_cnt < 5'd16);
        accept   = bus.sb_issue && ready;
        capture  = vpipe[SBOX_LAT-1];
        // cap_cnt can only reach 16 once every reserved byte has landed
        complete = (cap_cnt == 5'd16);
        transfer = complete && (!valid_q || bus.out_ready);
    end

    // out byte[r+4c] = bank[r + 4*((c+r)%4)], byte 0 in the top lane
    always_comb begin
        sr_state = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr_state[127 - 8*(r + 4*c) -: 8] = bank[4'(r + 4*((c + r) % 4))];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt    <= '0;
            cap_cnt    <= '0;
            vpipe      <= '0;
            state_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                bank[i] <= '0;
            end
        end else begin
            vpipe[0] <= accept;
            for (int unsigned i = 1; i < SBOX_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end

            if (bus.sb_issue && !ready) begin
                overflow_q <= 1'b1;
            end

            if (capture) begin
                bank[cap_cnt[3:0]] <= bus.sb_byte;
            end

            // a complete bank implies no accept and no capture this edge
            if (transfer) begin
                res_cnt <= '0;
                cap_cnt <= '0;
                state_q <= sr_state;
                valid_q <= 1'b1;
            end else begin
                if (accept) begin
                    res_cnt <= res_cnt + 5'd1;
                end
                if (capture) begin
                    cap_cnt <= cap_cnt + 5'd1;
                end
                if (valid_q && bus.out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.sb_ready  = ready;
    assign bus.out_state = state_q;
    assign bus.out_valid = valid_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_sbox_shift_rows_collector.sv
// Directed bench: table of 16-byte blocks with hand-computed ShiftRows results,
// plus backpressure, overrun, mid-block reset and SBOX_LAT=3 sequences.
module tb_sbox_shift_rows_collector;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_shift_rows_collector_if bus1 ();
    sbox_shift_rows_collector_if bus3 ();

    sbox_shift_rows_collector #(.SBOX_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    sbox_shift_rows_collector #(.SBOX_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // S-box modelled as a pure register delay of the desired output byte
    logic [7:0] sin1, sin3, p1;
    logic [7:0] p3 [3];
    always @(posedge clk) begin
        p1    <= sin1;
        p3[0] <= sin3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.sb_byte = p1;
    assign bus3.sb_byte = p3[2];

    typedef struct {
        logic [127:0] din;
        logic [15:0]  gaps;
        logic [127:0] expect_state;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic iss, input logic [7:0] b);
        if (sel == 0) begin
            bus1.sb_issue = iss;
            sin1 = b;
        end else begin
            bus3.sb_issue = iss;
            sin3 = b;
        end
    endtask

    function automatic logic rd_ready(input int sel);
        return (sel == 0) ? bus1.sb_ready : bus3.sb_ready;
    endfunction
    function automatic logic rd_valid(input int sel);
        return (sel == 0) ? bus1.out_valid : bus3.out_valid;
    endfunction
    function automatic logic [127:0] rd_state(input int sel);
        return (sel == 0) ? bus1.out_state : bus3.out_state;
    endfunction

    // gaps[k] inserts two idle cycles before byte k; e = edge count of last issue
    task automatic issue_block(input int sel, input logic [127:0] din, input logic [15:0] gaps,
                               input int nbytes, output int e);
        int n;
        for (int k = 0; k < nbytes; k++) begin
            if (gaps[k]) begin
                repeat (2) begin
                    drive(sel, 1'b0, 8'($urandom));
                    tick();
                end
            end
            n = 0;
            while (!rd_ready(sel) && n < 100) begin
                tick();
                n++;
            end
            if (n == 100) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout: sb_ready stayed 0 required 1");
            end
            drive(sel, 1'b1, din[127 - 8*k -: 8]);
            tick();
            drive(sel, 1'b0, 8'($urandom));
        end
        e = cyc;
    endtask

    task automatic wait_valid(input int sel, output int t);
        int n = 0;
        while (!rd_valid(sel) && n < 60) begin
            tick();
            n++;
        end
        if (n == 60) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: out_valid stayed 0 required 1");
        end
        t = cyc;
    endtask

    initial begin
        int e, t;

        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 16'h0000, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 16'h0000, 128'h00050a0f04090e03080d02070c01060b};
        vecs[2] = '{128'h00102030405060708090a0b0c0d0e0f0, 16'h8005, 128'h0050a0f04090e03080d02070c01060b0};
        vecs[3] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 16'ha000, 128'hf0f5fafff4f9fef3f8fdf2f7fcf1f6fb};

        rst_n = 1'b0;
        bus1.sb_issue = 1'b0; bus1.out_ready = 1'b1; sin1 = '0;
        bus3.sb_issue = 1'b0; bus3.out_ready = 1'b1; sin3 = '0;
        #12;
        check("rst_ready", bus1.sb_ready, 1'b1);
        check("rst_valid", bus1.out_valid, 1'b0);
        check("rst_state", bus1.out_state, '0);
        check("rst_overflow", bus1.overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // main table: out_ready held high, 1-cycle pulse, latency E+2
        for (int v = 0; v < 4; v++) begin
            issue_block(0, vecs[v].din, vecs[v].gaps, 16, e);
            wait_valid(0, t);
            check($sformatf("vec%0d_latency", v), 128'(t), 128'(e + 2));
            check($sformatf("vec%0d_state", v), bus1.out_state, vecs[v].expect_state);
            check($sformatf("vec%0d_ready_after", v), bus1.sb_ready, 1'b1);
            tick();
            check($sformatf("vec%0d_pulse", v), bus1.out_valid, 1'b0);
            check($sformatf("vec%0d_overflow", v), bus1.overflow, 1'b0);
        end

        // backpressure: A held, B fills bank, 17th issue overruns
        bus1.out_ready = 1'b0;
        issue_block(0, vecs[1].din, 16'h0000, 16, e);
        wait_valid(0, t);
        check("bp_a_state", bus1.out_state, vecs[1].expect_state);
        issue_block(0, vecs[3].din, 16'h0000, 16, e);
        repeat (4) tick();
        check("bp_full_ready", bus1.sb_ready, 1'b0);
        check("bp_hold_valid", bus1.out_valid, 1'b1);
        check("bp_hold_state", bus1.out_state, vecs[1].expect_state);
        drive(0, 1'b1, 8'h5a);
        tick();
        drive(0, 1'b0, 8'h00);
        check("ovf_set", bus1.overflow, 1'b1);
        check("ovf_state_held", bus1.out_state, vecs[1].expect_state);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("bp_b_valid", bus1.out_valid, 1'b1);
        check("bp_b_state", bus1.out_state, vecs[3].expect_state);
        tick();
        check("bp_b_stable", bus1.out_state, vecs[3].expect_state);
        bus1.out_ready = 1'b1;
        tick();
        check("bp_drain", bus1.out_valid, 1'b0);
        issue_block(0, vecs[0].din, 16'h0000, 16, e);
        wait_valid(0, t);
        check("ovf_next_state", bus1.out_state, vecs[0].expect_state);
        check("ovf_sticky", bus1.overflow, 1'b1);
        tick();

        // mid-block reset with a held output and 9 bytes in progress
        bus1.out_ready = 1'b0;
        issue_block(0, vecs[2].din, 16'h0000, 16, e);
        wait_valid(0, t);
        issue_block(0, vecs[1].din, 16'h0000, 9, e);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_valid", bus1.out_valid, 1'b0);
        check("mrst_state", bus1.out_state, '0);
        check("mrst_ready", bus1.sb_ready, 1'b1);
        check("mrst_overflow", bus1.overflow, 1'b0);
        #1 rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        issue_block(0, vecs[3].din, 16'h0000, 16, e);
        wait_valid(0, t);
        check("mrst_latency", 128'(t), 128'(e + 2));
        check("mrst_state_after", bus1.out_state, vecs[3].expect_state);

        // SBOX_LAT=3 instance
        issue_block(1, vecs[0].din, 16'h0000, 16, e);
        wait_valid(1, t);
        check("lat3_latency", 128'(t), 128'(e + 4));
        check("lat3_state", rd_state(1), vecs[0].expect_state);
        tick();
        check("lat3_pulse", rd_valid(1), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sbox_shift_rows_collector.md
Name: sbox_shift_rows_collector

Overview:
- Byte-serial ShiftRows stage directly downstream of the registered byte-wide S-box stage. It consumes one substituted byte per cycle from the S-box output.
- The block tracks S-box latency internally, gathers 16 bytes into an AES state, and applies the ShiftRows permutation. It presents the 128-bit result to MixColumns/AddRoundKey with a valid/ready handshake.
- A credit signal throttles the controller that issues bytes into the S-box.

Parameters:
SBOX_LAT, 1, clock cycles from a byte being presented at the S-box input to its result appearing on sb_byte (must be >= 1).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sb_issue  input  1  controller is presenting a byte to the S-box input this cycle
sb_ready  output  1  block can accept an issue this cycle (credit available)
sb_byte  input  8  S-box output byte, valid SBOX_LAT cycles after its accepted issue
out_state  output  128  ShiftRows-permuted state, byte 0 in [127:120]
out_valid  output  1  out_state holds a complete block
out_ready  input  1  consumer accepts out_state
overflow  output  1  sticky error: sb_issue asserted while sb_ready low

Behaviour:
- Reset (async assert, sync release): res_cnt=0, cap_cnt=0, valid pipe cleared, bank cleared, out_valid=0, out_state=0, overflow=0, sb_ready=1. In-flight bytes at reset are discarded.
- Accept rule: an issue is accepted when sb_issue && sb_ready at a rising edge. res_cnt (0..16) increments on each accepted issue.
- sb_ready = (res_cnt < 16), combinational from registers.
- Issue while not ready: the byte is ignored and overflow is set (cleared only by reset).
- Valid pipe: a shift register of depth SBOX_LAT carries the accepted-issue flag. When its tail is 1, sb_byte is written to bank[cap_cnt] and cap_cnt increments.
- Byte k has row k%4 and column k/4 (column-major, FIPS-197 input order).
- Completion: the bank is complete when cap_cnt==16, which requires res_cnt==16 with nothing in flight.
- Transfer occurs at the edge where the bank is complete and (!out_valid || out_ready). On transfer:
  - out_state <= SR(bank).
  - out_valid <= 1.
  - res_cnt <= 0 and cap_cnt <= 0, so sb_ready rises the next cycle.
- Handshake with no bank ready: at an edge with out_valid && out_ready and no transfer, out_valid <= 0.
- Handshake and transfer on the same edge: transfer wins, out_valid stays 1 and new data is loaded (back-to-back blocks).
- ShiftRows: out byte[r+4c] = bank[r+4*((c+r)%4)]. Explicitly:
  - out0..15 = in0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11.
- Stability: while out_valid && !out_ready, out_state and out_valid must not change.
- Latency: if the 16th accepted issue is at edge E, its byte is captured at edge E+SBOX_LAT. out_valid is high after edge E+SBOX_LAT+1 (if the output is free).
- Throughput gap: sb_ready is low from after E until transfer. With SBOX_LAT=1 and a free output, the minimum period is 18 cycles per block.
- Full condition: a complete bank plus a held output register blocks further issues (sb_ready=0) until out_ready.
- No arithmetic is performed; the block is a pure permutation and storage stage.

Test Plan:
1. FIPS-197 round 1: issue the 16 bytes whose S-box outputs are d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, with out_ready=1 -> out_state = d4bf5d30e0b452aeb84111f11e2798e5, out_valid high 1 cycle after the 16th capture, and pulses for exactly 1 cycle.
2. Backpressure: hold out_ready=0 and complete block A, then issue 16 bytes of block B -> B fills the bank and sb_ready stays 0. out_state holds A unchanged. Raise out_ready for 1 cycle -> B loads at that edge and out_valid stays 1.
3. Credit overrun: issue a 17th byte while sb_ready=0 -> the byte is dropped, overflow=1 and stays 1, and the next block's output is still correct.
4. Gapped issue: issue 16 bytes with random idle cycles, including a gap between bytes 15 and 16 -> correct permutation, and out_valid only after the final capture.
5. Mid-block reset: after 9 accepted issues, pulse rst_n low asynchronously between edges -> all outputs are 0 immediately and sb_ready=1. A fresh 16-byte block afterwards gives the correct result with no stale bytes.
6. SBOX_LAT=3 build: repeat test 1 -> same out_state, with out_valid 3 cycles after the 16th issue edge + 1.
